hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use and branch
// bubbles, multi-cycle MDU hold with timeout, and perf counters.
// Ports:
//   clk, reset         : clock, sync active-high reset
//   rs*_d/rs*_e/rd_*   : stage register indices
//   load_e, pc_src_e   : execute load / taken redirect
//   reg_write_m/_w     : M and W write enables
//   mdu_start_e/done   : MDU op in execute / result valid
//   forward_a/b_e      : 00 regfile, 01 WB, 10 MEM
//   stall_*, flush_*   : pipeline register controls
//   mdu_err            : sticky MDU timeout flag
//   stall_cnt/flush_cnt: saturating event counters
module hazard_ctrl #(
   parameter int MDU_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic [4:0] rs1_e,
   input  logic [4:0] rs2_e,
   input  logic [4:0] rd_e,
   input  logic       load_e,
   input  logic       pc_src_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   input  logic       mdu_start_e,
   input  logic       mdu_done,
   output logic [1:0] forward_a_e,
   output logic [1:0] forward_b_e,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       flush_d,
   output logic       flush_e,
   output logic       flush_m,
   output logic       mdu_err,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic {RUN, MDU_WAIT} state_t;

   localparam logic [7:0] LP_TO_LAST = 8'(MDU_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_wcnt;
   logic        r_err;
   logic [15:0] r_scnt;
   logic [15:0] r_fcnt;
   logic        w_timeout;
   logic        w_hold;
   logic        w_lu;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (reg_write_m && rd_m != 5'd0 && rd_m == rs)
         fwd_sel = 2'b10;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == rs)
         fwd_sel = 2'b01;
      else
         fwd_sel = 2'b00;
   endfunction

   always_comb begin
      forward_a_e = fwd_sel(rs1_e);
      forward_b_e = fwd_sel(rs2_e);
   end

   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      w_hold    = 1'b0;
      w_lu      = load_e && rd_e != 5'd0 &&
                  (rd_e == rs1_d || rd_e == rs2_d);
      unique case (r_state)
         RUN: begin
            w_hold = mdu_start_e && !mdu_done;
            if (w_hold)
               w_next = MDU_WAIT;
         end
         MDU_WAIT: begin
            // a result arriving on the last cycle beats the abort
            w_timeout = (r_wcnt == LP_TO_LAST) && !mdu_done;
            w_hold    = !mdu_done && !w_timeout;
            if (!w_hold)
               w_next = RUN;
         end
      endcase
   end

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      if (reset) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_m = 1'b1;
      end else if (w_hold) begin
         // freeze front end, drain a bubble past the MDU
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         flush_m = 1'b1;
      end else if (pc_src_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (w_lu) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_wcnt  <= 8'd0;
         r_err   <= 1'b0;
         r_scnt  <= 16'd0;
         r_fcnt  <= 16'd0;
      end else begin
         r_state <= w_next;
         // held at zero in RUN so each wait starts from zero
         if (r_state == RUN)
            r_wcnt <= 8'd0;
         else
            r_wcnt <= r_wcnt + 8'd1;
         if (w_timeout)
            r_err <= 1'b1;
         if (stall_f && r_scnt != 16'hFFFF)
            r_scnt <= r_scnt + 16'd1;
         if ((flush_d || flush_e) && r_fcnt != 16'hFFFF)
            r_fcnt <= r_fcnt + 16'd1;
      end
   end

   assign mdu_err   = r_err;
   assign stall_cnt = r_scnt;
   assign flush_cnt = r_fcnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed
// MDU/timeout/reset sequences, random run against a model.
module tb_hazard_ctrl;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       load_e, pc_src_e, reg_write_m, reg_write_w;
   logic       mdu_start_e, mdu_done;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, stall_e;
   logic       flush_d, flush_e, flush_m;
   logic       mdu_err;
   logic [15:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   // model state
   int m_wait = 0, m_cnt = 0, m_err = 0, m_sc = 0, m_fc = 0;
   int n_wait, n_cnt, n_err, n_sc, n_fc;

   always #5 clk = ~clk;

   hazard_ctrl #(.MDU_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .load_e(load_e), .pc_src_e(pc_src_e),
      .rd_m(rd_m), .rd_w(rd_w),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .mdu_start_e(mdu_start_e), .mdu_done(mdu_done),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .mdu_err(mdu_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic [4:0] r1d, r2d, r1e, r2e, rde;
      logic       ld, pc;
      logic [4:0] rdm, rdw;
      logic       wm, ww;
      logic [1:0] efa, efb;
      logic [2:0] est, efl;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] mfwd(input logic [4:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   // sample at negedge, compare with model, compute model next
   task automatic cyc_check();
      logic [2:0] est, efl;
      bit tmo, hold, lu;
      @(negedge clk);
      est = 3'b000;
      efl = 3'b000;
      tmo = (m_wait != 0) && m_cnt == TO - 1 && !mdu_done;
      hold = (m_wait != 0) ? (!mdu_done && !tmo)
                           : (mdu_start_e && !mdu_done);
      lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      if (reset) efl = 3'b111;
      else if (hold) begin est = 3'b111; efl = 3'b001; end
      else if (pc_src_e) efl = 3'b110;
      else if (lu) begin est = 3'b110; efl = 3'b010; end
      chk("fwd_a", 32'(forward_a_e), 32'(mfwd(rs1_e)));
      chk("fwd_b", 32'(forward_b_e), 32'(mfwd(rs2_e)));
      chk("stall", 32'({stall_f, stall_d, stall_e}), 32'(est));
      chk("flush", 32'({flush_d, flush_e, flush_m}), 32'(efl));
      chk("err", 32'(mdu_err), 32'(m_err));
      chk("scnt", 32'(stall_cnt), 32'(m_sc));
      chk("fcnt", 32'(flush_cnt), 32'(m_fc));
      if (reset) begin
         n_wait = 0; n_cnt = 0; n_err = 0; n_sc = 0; n_fc = 0;
      end else begin
         n_sc = (est[2] && m_sc < 65535) ? m_sc + 1 : m_sc;
         n_fc = ((efl[2] || efl[1]) && m_fc < 65535) ? m_fc + 1 : m_fc;
         n_err = (m_err != 0 || tmo) ? 1 : 0;
         n_cnt = (m_wait != 0) ? m_cnt + 1 : 0;
         if (m_wait != 0) n_wait = (mdu_done || tmo) ? 0 : 1;
         else n_wait = (mdu_start_e && !mdu_done) ? 1 : 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_wait = n_wait; m_cnt = n_cnt; m_err = n_err;
      m_sc = n_sc; m_fc = n_fc;
   endtask

   task automatic cyc();
      cyc_check();
      tick();
   endtask

   task automatic idle();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
      rd_m = 0; rd_w = 0; load_e = 0; pc_src_e = 0;
      reg_write_m = 0; reg_write_w = 0;
      mdu_start_e = 0; mdu_done = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      cyc();
      reset = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      @(posedge clk);
      #1;
      cyc();
      cyc();
      reset = 0;

      // vector table
      tbl[0]  = '{0,0,5,0,0, 0,0, 5,5,1,1, 2'b10,2'b00,3'b000,3'b000};
      tbl[1]  = '{0,0,5,0,0, 0,0, 5,5,0,1, 2'b01,2'b00,3'b000,3'b000};
      tbl[2]  = '{0,0,5,0,0, 0,0, 0,0,1,1, 2'b00,2'b00,3'b000,3'b000};
      tbl[3]  = '{0,0,3,9,0, 0,0, 9,3,1,1, 2'b01,2'b10,3'b000,3'b000};
      tbl[4]  = '{0,7,0,0,7, 1,0, 0,0,0,0, 2'b00,2'b00,3'b110,3'b010};
      tbl[5]  = '{0,7,0,0,7, 1,1, 0,0,0,0, 2'b00,2'b00,3'b000,3'b110};
      tbl[6]  = '{1,2,0,0,3, 0,1, 0,0,0,0, 2'b00,2'b00,3'b000,3'b110};
      tbl[7]  = '{0,0,0,0,0, 1,0, 0,0,0,0, 2'b00,2'b00,3'b000,3'b000};
      tbl[8]  = '{4,1,0,0,4, 1,0, 0,0,0,0, 2'b00,2'b00,3'b110,3'b010};
      tbl[9]  = '{4,1,0,0,4, 0,0, 0,0,0,0, 2'b00,2'b00,3'b000,3'b000};
      tbl[10] = '{0,0,12,12,0, 0,0, 12,12,0,1,
                  2'b01,2'b01,3'b000,3'b000};
      foreach (tbl[i]) begin
         rs1_d = tbl[i].r1d; rs2_d = tbl[i].r2d;
         rs1_e = tbl[i].r1e; rs2_e = tbl[i].r2e;
         rd_e = tbl[i].rde; load_e = tbl[i].ld;
         pc_src_e = tbl[i].pc; rd_m = tbl[i].rdm;
         rd_w = tbl[i].rdw; reg_write_m = tbl[i].wm;
         reg_write_w = tbl[i].ww;
         cyc_check();
         chk($sformatf("tbl%0d_fa", i), 32'(forward_a_e),
             32'(tbl[i].efa));
         chk($sformatf("tbl%0d_fb", i), 32'(forward_b_e),
             32'(tbl[i].efb));
         chk($sformatf("tbl%0d_st", i),
             32'({stall_f, stall_d, stall_e}), 32'(tbl[i].est));
         chk($sformatf("tbl%0d_fl", i),
             32'({flush_d, flush_e, flush_m}), 32'(tbl[i].efl));
         tick();
      end
      idle();

      // load-use bumps stall counter by exactly one
      do_reset();
      load_e = 1; rd_e = 7; rs2_d = 7;
      cyc_check();
      chk("lu_scnt0", 32'(stall_cnt), 32'd0);
      tick();
      idle();
      cyc_check();
      chk("lu_scnt1", 32'(stall_cnt), 32'd1);
      chk("lu_gone", 32'(stall_f), 32'd0);
      tick();

      // MDU: done arrives on cycle 4
      do_reset();
      mdu_start_e = 1;
      for (int c = 0; c < 4; c++) begin
         cyc_check();
         chk($sformatf("mdu_c%0d", c),
             32'({stall_f, stall_d, stall_e, flush_m}), 32'hF);
         tick();
      end
      mdu_done = 1;
      cyc_check();
      chk("mdu_c4", 32'({stall_f, stall_d, stall_e, flush_m}), 32'h0);
      tick();
      idle();
      cyc_check();
      chk("mdu_c5", 32'(stall_f), 32'd0);
      chk("mdu_scnt", 32'(stall_cnt), 32'd4);
      tick();

      // start and done together: no stall at all
      mdu_start_e = 1; mdu_done = 1;
      cyc_check();
      chk("mdu_same", 32'(stall_f), 32'd0);
      tick();
      idle();

      // timeout, start held and no done
      do_reset();
      mdu_start_e = 1;
      pc_src_e = 1;
      for (int c = 0; c < 4; c++) begin
         cyc_check();
         chk($sformatf("to_c%0d", c),
             32'({stall_f, flush_d, flush_m}), 32'b101);
         tick();
      end
      pc_src_e = 0;
      cyc_check();
      chk("to_drop", 32'(stall_f), 32'd0);
      chk("to_err0", 32'(mdu_err), 32'd0);
      tick();
      mdu_start_e = 0;
      for (int c = 0; c < 3; c++) begin
         cyc_check();
         chk("to_err", 32'(mdu_err), 32'd1);
         tick();
      end
      do_reset();
      cyc_check();
      chk("to_errclr", 32'(mdu_err), 32'd0);
      tick();

      // reset in the middle of a wait
      mdu_start_e = 1;
      cyc();
      cyc();
      reset = 1;
      cyc_check();
      chk("rst_st", 32'({stall_f, stall_d, stall_e}), 32'd0);
      chk("rst_fl", 32'({flush_d, flush_e, flush_m}), 32'h7);
      tick();
      reset = 0;
      mdu_start_e = 0;
      cyc_check();
      chk("rst_run", 32'(stall_f), 32'd0);
      chk("rst_err", 32'(mdu_err), 32'd0);
      tick();

      // random against model
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         rs1_d = 5'($urandom_range(0, 3));
         rs2_d = 5'($urandom_range(0, 3));
         rs1_e = 5'($urandom_range(0, 3));
         rs2_e = 5'($urandom_range(0, 3));
         rd_e = 5'($urandom_range(0, 3));
         rd_m = 5'($urandom_range(0, 3));
         rd_w = 5'($urandom_range(0, 3));
         load_e = 1'($urandom_range(0, 1));
         pc_src_e = ($urandom_range(0, 3) == 0);
         reg_write_m = 1'($urandom_range(0, 1));
         reg_write_w = 1'($urandom_range(0, 1));
         mdu_start_e = ($urandom_range(0, 2) == 0);
         mdu_done = ($urandom_range(0, 5) == 0);
         cyc();
      end
      idle();
      reset = 0;

      // flush counter saturation
      do_reset();
      pc_src_e = 1;
      repeat (65600) @(posedge clk);
      #1;
      chk("sat_fc", 32'(flush_cnt), 32'hFFFF);
      chk("sat_sc", 32'(stall_cnt), 32'd0);
      @(posedge clk);
      #1;
      chk("sat_hold", 32'(flush_cnt), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
